sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Streaming front end for sha256_core. It accepts a message of arbitrary length as a byte stream of DATA_W-bit beats.
- It assembles the message into 512-bit blocks and applies FIPS 180-4 padding: the 0x80 byte, zero fill, and the 64-bit big-endian bit length.
- It presents each block with first/last flags so a controller can drive the core's init (first block) and next (later blocks).
- It replaces the hand-built single-block padding used in benches, and generalises it to any message length and input width.

Parameters:
- DATA_W, 32, input beat width in bits; legal values are 8, 16, 32 and 64. BYTES = DATA_W/8.
- LEN_W, 64, width of the internal byte counter; legal range 8..61. The emitted bit length is zero-extended to 64 bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  padder can accept a beat
- s_data  in  DATA_W  message bytes; the first byte is in the MSBs
- s_last  in  1  beat is the final beat of the message
- s_nbytes  in  $clog2(BYTES+1)  valid bytes on a last beat (0..BYTES), left-justified; ignored when s_last=0
- blk_valid  out  1  blk holds a complete block
- blk_ready  in  1  consumer takes the block
- blk  out  512  padded block, big-endian; byte 0 is in bits 511:504
- blk_first  out  1  block is the first block of its message (drive init)
- blk_last  out  1  block is the final block of its message (digest valid after it)
- len_ovf  out  1  sticky: the byte counter wrapped during the current message

Behaviour:
- Reset: all outputs are 0 (s_ready=0, blk_valid=0, blk=0, blk_first=0, blk_last=0, len_ovf=0); state=ACCUM, fill=0, bytecnt=0. Asserting reset_n low mid-message aborts the message immediately. On release, s_ready rises in the first clock after reset_n goes high.
- Handshakes:
  - An input beat transfers on s_valid&s_ready.
  - A block transfers on blk_valid&blk_ready.
  - blk and its flags stay stable while blk_valid=1 and blk_ready=0.
- s_ready is 1 only in state ACCUM, so input stalls while a block is pending.
- States:
  - ACCUM: non-last beat → write BYTES bytes at offset fill; fill += BYTES; bytecnt += BYTES. If fill reaches 64 → EMIT_DATA.
  - ACCUM, last beat with n = s_nbytes:
    - write n bytes; k = fill + n; bytecnt += n.
    - k==64 → EMIT_DATA with pad_pending=1 (the padding goes into the next block).
    - k≤55 → write 0x80 at byte k, zeros in bytes k+1..55, length in bytes 56..63 → EMIT_FINAL.
    - 56≤k≤63 → write 0x80 at byte k, zeros to byte 63 → EMIT_PAD1.
  - EMIT_DATA: blk_valid=1, blk_last=0. On transfer: fill=0. If pad_pending, build 0x80 followed by zeros and the length → EMIT_FINAL; otherwise → ACCUM.
  - EMIT_PAD1: blk_last=0. On transfer: build all zeros with the length in bytes 56..63 → EMIT_FINAL.
  - EMIT_FINAL: blk_last=1. On transfer: clear bytecnt, fill, first_flag and len_ovf → ACCUM.
- Latency: blk_valid asserts in the cycle after the clock edge that accepts the completing beat. Throughput is one block per 64/BYTES+1 cycles when blk_ready is held at 1.
- Padding arithmetic: bit length = bytecnt·8, placed in the low bits of the 64-bit field. Bits above LEN_W+3 are 0.
- blk_first is 1 on the first emitted block after reset or after an EMIT_FINAL transfer, and 0 on every other block. A 1-block message has blk_first=1 and blk_last=1 together.
- Empty message (s_last with s_nbytes=0 and fill=0): one block 0x80, 0…0, length 0.
- Counter wrap: bytecnt wraps modulo 2^LEN_W, len_ovf is set and the padder keeps running; the emitted length is the wrapped value.
- Non-last beats are always full width. Because fill is always a multiple of BYTES before a last beat, a beat never straddles a block boundary.
- s_nbytes > BYTES is treated as BYTES.

Decomposition:
- Package sha256_pkg: BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80, state enum (ACCUM, EMIT_DATA, EMIT_PAD1, EMIT_FINAL), and a helper function that builds the length field.
- One sub-module is natural: sha256_byte_insert, which is combinational. It writes up to BYTES bytes plus an optional 0x80 marker at a byte offset into the 512-bit buffer and masks the trailing bytes to zero.

Test Plan:
- DATA_W=32, "abc": beat 0x61626300, last, nbytes=3 → one block 0x6162638000…0018, first=1, last=1.
- DATA_W=32, "Roland": beat 0x526f6c61, then 0x6e640000 last nbytes=2 → block 0x526f6c616e648000…0030. Feeding it to sha256_core gives a1ef7bf9…88276fcc.
- 56-byte message (DATA_W=64, 7 beats) → block 1 = data, byte 56=0x80, rest 0, last=0; block 2 = zeros…00000000000001c0, first=0, last=1.
- 64-byte message → block 1 = data only; block 2 = 0x8000…0000000000000200; blk_ready held 0 for 5 cycles mid-stream → blk stable and s_ready=0 throughout.
- Empty message (DATA_W=8, s_last nbytes=0) → 0x80 00…00 with a zero length field. Back-to-back with "abc": the second message's block has blk_first=1 and a length of 0x18.
- Reset: reset_n=0 after 20 bytes → outputs 0 immediately. After release, "abc" yields the correct single block with no residue.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Purpose  : Shared constants, FSM state type and length-field helper for the
//             SHA-256 message padder.
//  Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        ACCUM      = 2'd0,
        EMIT_DATA  = 2'd1,
        EMIT_PAD1  = 2'd2,
        EMIT_FINAL = 2'd3
    } state_t;

    // Message length in bits for the trailing 64-bit big-endian field.
    function automatic logic [63:0] len_field(input logic [63:0] byte_count);
        return byte_count << 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_byte_insert.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_byte_insert
//  Purpose  : Combinational block-buffer writer. Places up to BYTES beat bytes
//             at a byte offset, optionally follows them with the 0x80 marker,
//             and optionally zeroes every byte after the marker position.
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_byte_insert
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [511:0]        i_buf,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [6:0]          i_offset,
    input  logic [6:0]          i_nbytes,
    input  logic                i_marker,
    input  logic                i_mask_tail,
    output logic [511:0]        o_buf
);

    // Beat bytes aligned to their destination: byte 0 of the beat lands at i_offset.
    logic [511:0] w_shift;
    logic [7:0]   w_end;

    assign w_shift = {i_data, {(512-DATA_W){1'b0}}} >> {i_offset, 3'b000};
    assign w_end   = {1'b0, i_offset} + {1'b0, i_nbytes};

    // Per-byte select: beat data, marker, zero tail, or the old buffer contents.
    for (genvar b = 0; b < BLOCK_BYTES; b++) begin : g_byte
        localparam logic [7:0] c_idx = 8'(b);
        logic w_in_data;
        logic w_is_mark;
        logic w_is_tail;

        assign w_in_data = (c_idx >= {1'b0, i_offset}) && (c_idx < w_end);
        assign w_is_mark = i_marker && (c_idx == w_end);
        assign w_is_tail = i_mask_tail && (c_idx > w_end);

        assign o_buf[511-8*b -: 8] = w_in_data ? w_shift[511-8*b -: 8] :
                                     w_is_mark ? PAD_BYTE              :
                                     w_is_tail ? 8'h00                 :
                                                 i_buf[511-8*b -: 8];
    end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_msg_padder
//  Purpose  : Streaming SHA-256 front end. Packs a byte stream into 512-bit
//             blocks, appends 0x80 / zero fill / 64-bit bit length, and tags
//             each block with first/last flags for the hash controller.
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 64
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_W-1:0]                  s_data,
    input  logic                               s_last,
    input  logic [$clog2(DATA_W/8+1)-1:0]      s_nbytes,
    output logic                               blk_valid,
    input  logic                               blk_ready,
    output logic [511:0]                       blk,
    output logic                               blk_first,
    output logic                               blk_last,
    output logic                               len_ovf
);

    localparam int BYTES = DATA_W / 8;
    localparam int NB_W  = $clog2(BYTES + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [511:0]       r_buf;
    logic [511:0]       w_buf_nxt;
    logic [6:0]         r_fill;
    logic [6:0]         w_fill_nxt;
    logic [LEN_W-1:0]   r_bytecnt;
    logic [LEN_W-1:0]   w_bytecnt_nxt;
    logic               r_pad_pending;
    logic               w_pad_nxt;
    logic               r_first_done;
    logic               w_first_done_nxt;
    logic               r_len_ovf;
    logic               w_ovf_nxt;
    logic               r_run;

    logic               w_beat;
    logic [NB_W-1:0]    w_nb_clip;
    logic [6:0]         w_n;
    logic [6:0]         w_k;
    logic [LEN_W:0]     w_cnt_sum;
    logic [63:0]        w_len_new;
    logic [63:0]        w_len_cur;
    logic [511:0]       w_ins_buf;

    assign w_beat    = s_valid & s_ready;
    assign w_nb_clip = (s_nbytes > NB_W'(BYTES)) ? NB_W'(BYTES) : s_nbytes;
    assign w_n       = s_last ? 7'(w_nb_clip) : 7'(BYTES);
    assign w_k       = r_fill + w_n;
    assign w_cnt_sum = {1'b0, r_bytecnt} + (LEN_W+1)'(w_n);
    assign w_len_new = len_field(64'(w_cnt_sum[LEN_W-1:0]));
    assign w_len_cur = len_field(64'(r_bytecnt));

    sha256_byte_insert #(
        .DATA_W (DATA_W)
    ) u_insert (
        .i_buf       (r_buf),
        .i_data      (s_data),
        .i_offset    (r_fill),
        .i_nbytes    (w_n),
        .i_marker    (s_last),
        .i_mask_tail (s_last),
        .o_buf       (w_ins_buf)
    );

    // Next-state and datapath update for accumulate / emit sequencing.
    always_comb begin
        w_state_nxt      = r_state;
        w_buf_nxt        = r_buf;
        w_fill_nxt       = r_fill;
        w_bytecnt_nxt    = r_bytecnt;
        w_pad_nxt        = r_pad_pending;
        w_first_done_nxt = r_first_done;
        w_ovf_nxt        = r_len_ovf;
        case (r_state)
            ACCUM: begin
                if (w_beat) begin
                    w_bytecnt_nxt = w_cnt_sum[LEN_W-1:0];
                    w_ovf_nxt     = r_len_ovf | w_cnt_sum[LEN_W];
                    w_buf_nxt     = w_ins_buf;
                    w_fill_nxt    = w_k;
                    if (!s_last) begin
                        if (w_k == 7'(BLOCK_BYTES)) w_state_nxt = EMIT_DATA;
                    end else if (w_k == 7'(BLOCK_BYTES)) begin
                        // Block is full of data; the marker starts the next block.
                        w_pad_nxt   = 1'b1;
                        w_state_nxt = EMIT_DATA;
                    end else if (w_k < 7'(LEN_OFFSET)) begin
                        w_buf_nxt   = {w_ins_buf[511:64], w_len_new};
                        w_state_nxt = EMIT_FINAL;
                    end else begin
                        // Marker fits but the length field does not.
                        w_state_nxt = EMIT_PAD1;
                    end
                end
            end
            EMIT_DATA: begin
                if (blk_ready) begin
                    w_fill_nxt       = 7'd0;
                    w_first_done_nxt = 1'b1;
                    if (r_pad_pending) begin
                        w_buf_nxt   = {PAD_BYTE, 440'd0, w_len_cur};
                        w_pad_nxt   = 1'b0;
                        w_state_nxt = EMIT_FINAL;
                    end else begin
                        w_state_nxt = ACCUM;
                    end
                end
            end
            EMIT_PAD1: begin
                if (blk_ready) begin
                    w_fill_nxt       = 7'd0;
                    w_first_done_nxt = 1'b1;
                    w_buf_nxt        = {448'd0, w_len_cur};
                    w_state_nxt      = EMIT_FINAL;
                end
            end
            EMIT_FINAL: begin
                if (blk_ready) begin
                    w_fill_nxt       = 7'd0;
                    w_bytecnt_nxt    = '0;
                    w_first_done_nxt = 1'b0;
                    w_ovf_nxt        = 1'b0;
                    w_pad_nxt        = 1'b0;
                    w_state_nxt      = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ACCUM;
        else          r_state <= w_state_nxt;
    end

    // Block buffer, counters and flags; r_run holds s_ready low until the first clock out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf         <= '0;
            r_fill        <= 7'd0;
            r_bytecnt     <= '0;
            r_pad_pending <= 1'b0;
            r_first_done  <= 1'b0;
            r_len_ovf     <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_buf         <= w_buf_nxt;
            r_fill        <= w_fill_nxt;
            r_bytecnt     <= w_bytecnt_nxt;
            r_pad_pending <= w_pad_nxt;
            r_first_done  <= w_first_done_nxt;
            r_len_ovf     <= w_ovf_nxt;
            r_run         <= 1'b1;
        end
    end

    assign s_ready   = r_run & (r_state == ACCUM);
    assign blk_valid = (r_state != ACCUM);
    assign blk       = r_buf;
    assign blk_first = blk_valid & ~r_first_done;
    assign blk_last  = (r_state == EMIT_FINAL);
    assign len_ovf   = r_len_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_msg_padder
//  Purpose  : Self-checking bench for sha256_msg_padder. Four instances:
//             [0] 32-bit, [1] 64-bit, [2] 8-bit, [3] 64-bit with 8-bit counter.
//             Expected blocks {first,last,blk} are queued as stimulus is sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sv[4], sl[4], rdy[4], bv[4], br[4], bf[4], bl[4], ovf[4];
    logic [511:0] blkv[4];
    logic [31:0]  sd32;
    logic [63:0]  sd64, sdw;
    logic [7:0]   sd8;
    logic [2:0]   nb32;
    logic [3:0]   nb64, nbw;
    logic [0:0]   nb8;
    logic [513:0] q[4][$];
    logic [513:0] mon_exp;
    logic [511:0] e1, e2;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    sha256_msg_padder #(.DATA_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .s_valid(sv[0]), .s_ready(rdy[0]), .s_data(sd32),
        .s_last(sl[0]), .s_nbytes(nb32), .blk_valid(bv[0]), .blk_ready(br[0]), .blk(blkv[0]),
        .blk_first(bf[0]), .blk_last(bl[0]), .len_ovf(ovf[0]));
    sha256_msg_padder #(.DATA_W(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .s_valid(sv[1]), .s_ready(rdy[1]), .s_data(sd64),
        .s_last(sl[1]), .s_nbytes(nb64), .blk_valid(bv[1]), .blk_ready(br[1]), .blk(blkv[1]),
        .blk_first(bf[1]), .blk_last(bl[1]), .len_ovf(ovf[1]));
    sha256_msg_padder #(.DATA_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .s_valid(sv[2]), .s_ready(rdy[2]), .s_data(sd8),
        .s_last(sl[2]), .s_nbytes(nb8), .blk_valid(bv[2]), .blk_ready(br[2]), .blk(blkv[2]),
        .blk_first(bf[2]), .blk_last(bl[2]), .len_ovf(ovf[2]));
    sha256_msg_padder #(.DATA_W(64), .LEN_W(8)) dutw (
        .clk(clk), .reset_n(reset_n), .s_valid(sv[3]), .s_ready(rdy[3]), .s_data(sdw),
        .s_last(sl[3]), .s_nbytes(nbw), .blk_valid(bv[3]), .blk_ready(br[3]), .blk(blkv[3]),
        .blk_first(bf[3]), .blk_last(bl[3]), .len_ovf(ovf[3]));

    // Right-justified head of n bytes placed at byte 0, length OR-ed into the last 8 bytes.
    function automatic logic [511:0] mk(input logic [255:0] head, input int n, input logic [63:0] len);
        logic [511:0] r;
        r = 512'(head) << (512 - 8 * n);
        r[63:0] = r[63:0] | len;
        return r;
    endfunction

    // Bytes base, base+1, ... in the first n byte positions, zero elsewhere.
    function automatic logic [511:0] ramp(input int base, input int n);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[511-8*i -: 8] = 8'(base + i);
        return r;
    endfunction

    function automatic logic [63:0] beat64(input int base);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[63-8*b -: 8] = 8'(base + b);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send(input int i, input logic [63:0] d, input logic last, input int nb);
        bit ok;
        ok = 1'b0;
        case (i)
            0:       begin sd32 = d[31:0]; nb32 = 3'(nb); end
            1:       begin sd64 = d;       nb64 = 4'(nb); end
            2:       begin sd8  = d[7:0];  nb8  = 1'(nb); end
            default: begin sdw  = d;       nbw  = 4'(nb); end
        endcase
        sv[i] = 1'b1;
        sl[i] = last;
        for (int n = 0; n < 200 && !ok; n++) begin
            ok = rdy[i];
            @(posedge clk);
            #1;
        end
        sv[i] = 1'b0;
        sl[i] = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send%0d observed=timeout expected=accept", i);
        end
    endtask

    // Wait (bounded) for every queued block of instance i to be consumed.
    task automatic drain(input int i);
        for (int n = 0; n < 300 && q[i].size() != 0; n++) @(posedge clk);
        #1;
        checks++;
        assert (q[i].size() === 0) else begin
            errors++;
            $error("FAIL drain%0d observed=%0d expected=0 pending", i, q[i].size());
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_before_clk", 512'(rdy[0]), 512'd0);
        @(posedge clk);
        #1;
        chk("ready_after_clk", 512'(rdy[0]), 512'd1);
    endtask

    // Scoreboard: compare every transferred block against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bv[i] && br[i]) begin
                    checks++;
                    if (q[i].size() == 0) begin
                        errors++;
                        $error("FAIL blk%0d observed=unexpected block expected=none", i);
                    end else begin
                        mon_exp = q[i].pop_front();
                        assert ({bf[i], bl[i], blkv[i]} === mon_exp) else begin
                            errors++;
                            $error("FAIL blk%0d observed=%0h expected=%0h", i, {bf[i], bl[i], blkv[i]}, mon_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin sv[i] = 1'b0; sl[i] = 1'b0; br[i] = 1'b1; end
        sd32 = '0; sd64 = '0; sd8 = '0; sdw = '0; nb32 = '0; nb64 = '0; nb8 = '0; nbw = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 512'(rdy[0]), 512'd0);
        chk("rst_blk_valid", 512'(bv[0]), 512'd0);
        chk("rst_blk", blkv[0], 512'd0);
        chk("rst_flags", 512'({bf[0], bl[0], ovf[0]}), 512'd0);
        release_reset();

        // "abc" on 32-bit: single block, valid one cycle after the accepting edge
        q[0].push_back({1'b1, 1'b1, mk(256'h61626380, 4, 64'h18)});
        send(0, 64'h61626300, 1'b1, 3);
        chk("abc_latency", 512'(bv[0]), 512'd1);
        drain(0);

        // "Roland" on 32-bit
        q[0].push_back({1'b1, 1'b1, mk(256'h526f6c616e6480, 7, 64'h30)});
        send(0, 64'h526f6c61, 1'b0, 0);
        send(0, 64'h6e640000, 1'b1, 2);
        drain(0);

        // 56-byte message on 64-bit: marker fits, length spills to a second block
        e1 = ramp(1, 56) | (512'h80 << 56);
        q[1].push_back({1'b1, 1'b0, e1});
        q[1].push_back({1'b0, 1'b1, mk(256'h0, 0, 64'h1c0)});
        for (int j = 0; j < 7; j++) send(1, beat64(1 + 8 * j), (j == 6), 8);
        drain(1);

        // 64-byte message on 64-bit with a 5-cycle consumer stall on the data block
        e2 = ramp(8'h41, 64);
        q[1].push_back({1'b1, 1'b0, e2});
        q[1].push_back({1'b0, 1'b1, mk(256'h80, 1, 64'h200)});
        br[1] = 1'b0;
        for (int j = 0; j < 8; j++) send(1, beat64(8'h41 + 8 * j), (j == 7), 8);
        for (int n = 0; n < 50 && !bv[1]; n++) begin @(posedge clk); #1; end
        for (int c = 0; c < 5; c++) begin
            chk("stall_blk", blkv[1], e2);
            chk("stall_valid_ready", 512'({bv[1], rdy[1], bf[1], bl[1]}), 512'b1010);
            @(posedge clk);
            #1;
        end
        br[1] = 1'b1;
        drain(1);

        // Empty message then "abc" on 8-bit
        q[2].push_back({1'b1, 1'b1, mk(256'h80, 1, 64'h0)});
        send(2, 64'h0, 1'b1, 0);
        q[2].push_back({1'b1, 1'b1, mk(256'h61626380, 4, 64'h18)});
        send(2, 64'h61, 1'b0, 0);
        send(2, 64'h62, 1'b0, 0);
        send(2, 64'h63, 1'b1, 1);
        drain(2);

        // Counter wrap: 256 zero bytes then one more byte with an 8-bit counter
        for (int b = 0; b < 4; b++) q[3].push_back({(b == 0), 1'b0, 512'd0});
        q[3].push_back({1'b0, 1'b1, mk(256'h4180, 2, 64'h8)});
        for (int j = 0; j < 32; j++) send(3, 64'h0, 1'b0, 0);
        chk("ovf_set", 512'(ovf[3]), 512'd1);
        send(3, 64'h4100000000000000, 1'b1, 1);
        drain(3);
        chk("ovf_cleared", 512'(ovf[3]), 512'd0);

        // Reset mid-message on 32-bit after 20 bytes, then "abc" again
        for (int j = 0; j < 5; j++) send(0, 64'hdeadbeef, 1'b0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_s_ready", 512'(rdy[0]), 512'd0);
        chk("abort_blk_valid", 512'(bv[0]), 512'd0);
        chk("abort_blk", blkv[0], 512'd0);
        chk("abort_flags", 512'({bf[0], bl[0], ovf[0]}), 512'd0);
        release_reset();
        q[0].push_back({1'b1, 1'b1, mk(256'h61626380, 4, 64'h18)});
        send(0, 64'h61626300, 1'b1, 3);
        drain(0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
